// File: rtl/cpu_regs_pkg.sv
// +----------------------------------------------------------------------------+
// | cpu_regs_pkg : register selects, flag positions and stack FSM types         |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

package cpu_regs_pkg;

   typedef enum logic [3:0] {
      REG_A    = 4'd0,
      REG_F    = 4'd1,
      REG_B    = 4'd2,
      REG_C    = 4'd3,
      REG_D    = 4'd4,
      REG_E    = 4'd5,
      REG_H    = 4'd6,
      REG_L    = 4'd7,
      REG_AF   = 4'd8,
      REG_BC   = 4'd9,
      REG_DE   = 4'd10,
      REG_HL   = 4'd11,
      REG_SP   = 4'd12,
      REG_PC   = 4'd13,
      REG_NONE = 4'd14
   } reg_e;

   localparam int c_flag_z = 7;
   localparam int c_flag_n = 6;
   localparam int c_flag_h = 5;
   localparam int c_flag_c = 4;

   typedef enum logic {
      STK_PUSH = 1'b0,
      STK_POP  = 1'b1
   } stk_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_XFER = 2'd1,
      ST_DONE = 2'd2
   } stk_state_e;

   // Enable/value nibbles are ordered {Z,N,H,C}; the low nibble of F never holds state.
   function automatic logic [7:0] merge_flags(input logic [7:0] base,
                                              input logic [3:0] we,
                                              input logic [3:0] val);
      logic [7:0] f;
      f = {base[7:4], 4'b0000};
      if (we[3]) f[c_flag_z] = val[3];
      if (we[2]) f[c_flag_n] = val[2];
      if (we[1]) f[c_flag_h] = val[1];
      if (we[0]) f[c_flag_c] = val[0];
      return f;
   endfunction

endpackage

`default_nettype wire

// File: rtl/stack_sequencer.sv
// +----------------------------------------------------------------------------+
// | stack_sequencer : multi-byte push/pop FSM on a byte memory port            |
// | Optional SP_LIMIT_CHECK_EN adds stk_err and push underflow blocking. Rev 1.0|
// +----------------------------------------------------------------------------+
`default_nettype none

module stack_sequencer
   import cpu_regs_pkg::*;
#(
   parameter int unsigned          ADDR_W     = 16,
   parameter int unsigned          WORD_BYTES = 2,
   parameter logic [ADDR_W-1:0]    SP_LIMIT   = 16'hC000
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      stk_valid,
   output logic                      stk_ready,
   input  logic                      stk_op,
   input  logic [8*WORD_BYTES-1:0]   stk_wdata,
   output logic                      stk_done,
   output logic [8*WORD_BYTES-1:0]   stk_rdata,
`ifdef SP_LIMIT_CHECK_EN
   output logic                      stk_err,
`endif
   output logic                      mem_req,
   output logic                      mem_we,
   output logic [ADDR_W-1:0]         mem_addr,
   output logic [7:0]                mem_wdata,
   input  logic [7:0]                mem_rdata,
   input  logic                      mem_ack,
   input  logic [ADDR_W-1:0]         sp,
   output logic                      sp_we,
   output logic [ADDR_W-1:0]         sp_next,
   output logic                      sp_lock
);

   localparam int unsigned       c_dw    = 8 * WORD_BYTES;
   localparam logic [1:0]        c_last  = 2'(WORD_BYTES - 1);
   localparam logic [ADDR_W-1:0] c_one   = ADDR_W'(1);
`ifdef SP_LIMIT_CHECK_EN
   localparam logic              c_limit_en = 1'b1;
`else
   localparam logic              c_limit_en = 1'b0;
`endif

   stk_state_e        r_state;
   stk_op_e           r_op;
   logic [1:0]        r_cnt;
   logic [c_dw-1:0]   r_data;
   logic [c_dw-1:0]   r_rdata;

   logic [ADDR_W:0]   w_sp_dec;
   logic              w_below;
   logic              w_blocked;
   logic              w_push;
   logic [c_dw-1:0]   w_pop_shift;
   logic [ADDR_W-1:0] w_sp_dn;
   logic [ADDR_W-1:0] w_sp_up;

   // Borrow out of the extended subtraction flags a wrap below address zero.
   assign w_sp_dec    = {1'b0, sp} - (ADDR_W+1)'(WORD_BYTES);
   assign w_below     = w_sp_dec[ADDR_W] || (w_sp_dec[ADDR_W-1:0] < SP_LIMIT);
   assign w_blocked   = c_limit_en && w_below && (stk_op == STK_PUSH);
   assign w_pop_shift = c_dw'({mem_rdata, r_data} >> 8);
   assign w_push      = (r_op == STK_PUSH);
   assign w_sp_dn     = sp - c_one;
   assign w_sp_up     = sp + c_one;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_op    <= STK_PUSH;
         r_cnt   <= 2'd0;
         r_data  <= '0;
         r_rdata <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (stk_valid) begin
                  r_op    <= stk_op_e'(stk_op);
                  r_cnt   <= 2'd0;
                  r_data  <= stk_wdata;
                  r_state <= w_blocked ? ST_DONE : ST_XFER;
               end
            end
            ST_XFER: begin
               if (mem_ack) begin
                  r_cnt <= r_cnt + 2'd1;
                  // Push drains MSB first; pop fills from the top so the LSB ends lowest.
                  if (w_push) r_data <= r_data << 8;
                  else        r_data <= w_pop_shift;
                  if (r_cnt == c_last) begin
                     r_state <= ST_DONE;
                     if (!w_push) r_rdata <= w_pop_shift;
                  end
               end
            end
            ST_DONE: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

`ifdef SP_LIMIT_CHECK_EN
   logic r_err;
   always_ff @(posedge clk) begin
      if (!rst_n)                                  r_err <= 1'b0;
      else if (r_state == ST_IDLE && stk_valid)    r_err <= w_blocked;
      else if (r_state == ST_DONE)                 r_err <= 1'b0;
   end
   assign stk_err = r_err && (r_state == ST_DONE);
`endif

   assign stk_ready = (r_state == ST_IDLE);
   assign stk_done  = (r_state == ST_DONE);
   assign stk_rdata = r_rdata;
   assign mem_req   = (r_state == ST_XFER);
   assign mem_we    = w_push;
   assign mem_addr  = w_push ? w_sp_dn : sp;
   assign mem_wdata = r_data[c_dw-1 -: 8];
   assign sp_we     = (r_state == ST_XFER) && mem_ack;
   assign sp_next   = w_push ? w_sp_dn : w_sp_up;
   assign sp_lock   = (r_state != ST_IDLE) || stk_valid;

endmodule

`default_nettype wire

// File: rtl/cpu_regfile_stack.sv
// +----------------------------------------------------------------------------+
// | cpu_regfile_stack : SM83-style register file with stack push/pop unit      |
// | Optional SP_LIMIT_CHECK_EN adds stk_err output. Rev 1.0                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module cpu_regfile_stack
   import cpu_regs_pkg::*;
#(
   parameter int unsigned       ADDR_W     = 16,
   parameter int unsigned       WORD_BYTES = 2,
   parameter logic [ADDR_W-1:0] SP_RESET   = 16'hFFFE,
   parameter logic [ADDR_W-1:0] PC_RESET   = 16'h0100,
   parameter logic [ADDR_W-1:0] SP_LIMIT   = 16'hC000
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [3:0]                rd_sel,
   output logic [ADDR_W-1:0]         rd_data,
   input  logic                      wr_en,
   input  logic [3:0]                wr_sel,
   input  logic [ADDR_W-1:0]         wr_data,
   input  logic [3:0]                flag_we,
   input  logic [3:0]                flag_val,
   input  logic                      stk_valid,
   output logic                      stk_ready,
   input  logic                      stk_op,
   input  logic [8*WORD_BYTES-1:0]   stk_wdata,
   output logic                      stk_done,
   output logic [8*WORD_BYTES-1:0]   stk_rdata,
`ifdef SP_LIMIT_CHECK_EN
   output logic                      stk_err,
`endif
   output logic                      mem_req,
   output logic                      mem_we,
   output logic [ADDR_W-1:0]         mem_addr,
   output logic [7:0]                mem_wdata,
   input  logic [7:0]                mem_rdata,
   input  logic                      mem_ack,
   output logic [ADDR_W-1:0]         sp_out,
   output logic [ADDR_W-1:0]         pc_out,
   output logic [7:0]                f_out
);

   logic [7:0]        r_a, r_f, r_b, r_c, r_d, r_e, r_h, r_l;
   logic [ADDR_W-1:0] r_sp, r_pc;

   logic              w_sp_we;
   logic [ADDR_W-1:0] w_sp_next;
   logic              w_sp_lock;
   logic              w_f_wr;
   logic [7:0]        w_f_base;

   stack_sequencer #(
      .ADDR_W     (ADDR_W),
      .WORD_BYTES (WORD_BYTES),
      .SP_LIMIT   (SP_LIMIT)
   ) u_seq (
      .clk        (clk),
      .rst_n      (rst_n),
      .stk_valid  (stk_valid),
      .stk_ready  (stk_ready),
      .stk_op     (stk_op),
      .stk_wdata  (stk_wdata),
      .stk_done   (stk_done),
      .stk_rdata  (stk_rdata),
`ifdef SP_LIMIT_CHECK_EN
      .stk_err    (stk_err),
`endif
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .mem_ack    (mem_ack),
      .sp         (r_sp),
      .sp_we      (w_sp_we),
      .sp_next    (w_sp_next),
      .sp_lock    (w_sp_lock)
   );

   // F accepts writes from both the F and AF selects; flag enables then override.
   assign w_f_wr   = wr_en && (wr_sel == REG_F || wr_sel == REG_AF);
   assign w_f_base = w_f_wr ? wr_data[7:0] : r_f;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_a  <= 8'h00;
         r_f  <= 8'h00;
         r_b  <= 8'h00;
         r_c  <= 8'h00;
         r_d  <= 8'h00;
         r_e  <= 8'h00;
         r_h  <= 8'h00;
         r_l  <= 8'h00;
         r_sp <= SP_RESET;
         r_pc <= PC_RESET;
      end else begin
         r_f <= merge_flags(w_f_base, flag_we, flag_val);
         if (wr_en) begin
            case (reg_e'(wr_sel))
               REG_A:  r_a <= wr_data[7:0];
               REG_B:  r_b <= wr_data[7:0];
               REG_C:  r_c <= wr_data[7:0];
               REG_D:  r_d <= wr_data[7:0];
               REG_E:  r_e <= wr_data[7:0];
               REG_H:  r_h <= wr_data[7:0];
               REG_L:  r_l <= wr_data[7:0];
               REG_AF: r_a <= wr_data[15:8];
               REG_BC: begin r_b <= wr_data[15:8]; r_c <= wr_data[7:0]; end
               REG_DE: begin r_d <= wr_data[15:8]; r_e <= wr_data[7:0]; end
               REG_HL: begin r_h <= wr_data[15:8]; r_l <= wr_data[7:0]; end
               REG_PC: r_pc <= wr_data;
               default: ;
            endcase
         end
         // The stack unit owns SP from the accept cycle until it returns to idle.
         if (w_sp_we)
            r_sp <= w_sp_next;
         else if (wr_en && wr_sel == REG_SP && !w_sp_lock)
            r_sp <= wr_data;
      end
   end

   always_comb begin
      rd_data = '0;
      case (reg_e'(rd_sel))
         REG_A:  rd_data = ADDR_W'(r_a);
         REG_F:  rd_data = ADDR_W'(r_f);
         REG_B:  rd_data = ADDR_W'(r_b);
         REG_C:  rd_data = ADDR_W'(r_c);
         REG_D:  rd_data = ADDR_W'(r_d);
         REG_E:  rd_data = ADDR_W'(r_e);
         REG_H:  rd_data = ADDR_W'(r_h);
         REG_L:  rd_data = ADDR_W'(r_l);
         REG_AF: rd_data = ADDR_W'({r_a, r_f});
         REG_BC: rd_data = ADDR_W'({r_b, r_c});
         REG_DE: rd_data = ADDR_W'({r_d, r_e});
         REG_HL: rd_data = ADDR_W'({r_h, r_l});
         REG_SP: rd_data = r_sp;
         REG_PC: rd_data = r_pc;
         default: rd_data = '0;
      endcase
   end

   assign sp_out = r_sp;
   assign pc_out = r_pc;
   assign f_out  = r_f;

endmodule

`default_nettype wire

// File: tb/tb_cpu_regfile_stack.sv
// +----------------------------------------------------------------------------+
// | tb_cpu_regfile_stack : directed bench with memory model and scoreboard     |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_cpu_regfile_stack;
   import cpu_regs_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  rd_sel = 4'd0;
   logic [15:0] rd_data;
   logic        wr_en = 1'b0;
   logic [3:0]  wr_sel = 4'd0;
   logic [15:0] wr_data = 16'h0;
   logic [3:0]  flag_we = 4'd0;
   logic [3:0]  flag_val = 4'd0;
   logic        stk_valid = 1'b0;
   logic        stk_ready;
   logic        stk_op = 1'b0;
   logic [15:0] stk_wdata = 16'h0;
   logic        stk_done;
   logic [15:0] stk_rdata;
`ifdef SP_LIMIT_CHECK_EN
   logic        stk_err;
`endif
   logic        mem_req, mem_we;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata = 8'h00;
   logic        mem_ack = 1'b0;
   logic [15:0] sp_out, pc_out;
   logic [7:0]  f_out;

   always #5 clk = ~clk;

   cpu_regfile_stack dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rd_sel    (rd_sel),
      .rd_data   (rd_data),
      .wr_en     (wr_en),
      .wr_sel    (wr_sel),
      .wr_data   (wr_data),
      .flag_we   (flag_we),
      .flag_val  (flag_val),
      .stk_valid (stk_valid),
      .stk_ready (stk_ready),
      .stk_op    (stk_op),
      .stk_wdata (stk_wdata),
      .stk_done  (stk_done),
      .stk_rdata (stk_rdata),
`ifdef SP_LIMIT_CHECK_EN
      .stk_err   (stk_err),
`endif
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ack   (mem_ack),
      .sp_out    (sp_out),
      .pc_out    (pc_out),
      .f_out     (f_out)
   );

   int checks = 0;
   int errors = 0;

   logic [7:0]  mem [logic [15:0]];
   logic [23:0] exp_wr [$];
   logic [15:0] exp_sp [$];
   logic [15:0] exp_rd [$];
   int          delay = 0;
   int          wcnt = 0;
   logic        pend = 1'b0;
   logic [24:0] pend_bus = '0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Byte memory with programmable ack delay; writes are scored against the queue.
   always @(negedge clk) begin
      if (rst_n && mem_req) begin
         if (pend) check("addr_stable", {7'd0, mem_we, mem_addr, mem_wdata}, {7'd0, pend_bus});
         if (wcnt >= delay) begin
            mem_ack = 1'b1;
            wcnt    = 0;
            pend    = 1'b0;
            if (mem_we) begin
               mem[mem_addr] = mem_wdata;
               check("mem_wr", {8'd0, mem_addr, mem_wdata},
                     (exp_wr.size() > 0) ? {8'd0, exp_wr.pop_front()} : 32'hxxxxxxxx);
            end else begin
               mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : 8'h00;
            end
         end else begin
            mem_ack  = 1'b0;
            wcnt++;
            pend     = 1'b1;
            pend_bus = {mem_we, mem_addr, mem_wdata};
         end
      end else begin
         mem_ack = 1'b0;
         wcnt    = 0;
         pend    = 1'b0;
      end
   end

   task automatic wr_reg(input logic [3:0] sel, input logic [15:0] d,
                         input logic [3:0] fwe, input logic [3:0] fval);
      @(negedge clk);
      wr_en = 1'b1; wr_sel = sel; wr_data = d; flag_we = fwe; flag_val = fval;
      @(posedge clk); #1;
      wr_en = 1'b0; flag_we = 4'd0; flag_val = 4'd0;
   endtask

   task automatic set_flags(input logic [3:0] fwe, input logic [3:0] fval);
      @(negedge clk);
      flag_we = fwe; flag_val = fval;
      @(posedge clk); #1;
      flag_we = 4'd0; flag_val = 4'd0;
   endtask

   task automatic rd_chk(input string tag, input logic [3:0] sel, input logic [15:0] exp);
      rd_sel = sel;
      #1;
      check(tag, {16'd0, rd_data}, {16'd0, exp});
   endtask

   task automatic run_cmd(input logic op, input logic [15:0] wd, input int lat_exp,
                          input logic exp_err, input logic inject, input logic [15:0] junk);
      int lat;
      @(negedge clk);
      check("ready_idle", {31'd0, stk_ready}, 32'd1);
      stk_valid = 1'b1; stk_op = op; stk_wdata = wd;
      if (inject) begin wr_en = 1'b1; wr_sel = REG_SP; wr_data = junk; end
      @(posedge clk); #1;
      stk_valid = 1'b0;
      if (inject) wr_data = ~junk;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
         if (lat == 1) check("ready_busy", {31'd0, stk_ready}, 32'd0);
         if (lat == 2) wr_en = 1'b0;
      end while (!stk_done && lat < 64);
      wr_en = 1'b0;
      check("latency", lat, lat_exp);
      check("sp_done", {16'd0, sp_out}, {16'd0, exp_sp.pop_front()});
      if (op) check("rdata", {16'd0, stk_rdata}, {16'd0, exp_rd.pop_front()});
      check("wr_drained", exp_wr.size(), 0);
`ifdef SP_LIMIT_CHECK_EN
      check("stk_err", {31'd0, stk_err}, {31'd0, exp_err});
`else
      if (exp_err) check("stk_err_unsupported", 32'd0, 32'd1);
`endif
      @(negedge clk);
      check("done_pulse", {31'd0, stk_done}, 32'd0);
   endtask

   initial begin
      int seen_done;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_sp", {16'd0, sp_out}, 32'h0000FFFE);
      check("rst_pc", {16'd0, pc_out}, 32'h00000100);
      check("rst_ready", {31'd0, stk_ready}, 32'd1);
      check("rst_mem_req", {31'd0, mem_req}, 32'd0);
      check("rst_done", {31'd0, stk_done}, 32'd0);
      check("rst_rdata", {16'd0, stk_rdata}, 32'd0);
      rd_chk("rst_af", REG_AF, 16'h0000);

      // Read during a pair write returns the old value.
      @(negedge clk);
      wr_en = 1'b1; wr_sel = REG_AF; wr_data = 16'h12FF; rd_sel = REG_AF;
      #1 check("rd_old", {16'd0, rd_data}, 32'd0);
      @(posedge clk); #1;
      wr_en = 1'b0;
      rd_chk("af_write", REG_AF, 16'h12F0);
      set_flags(4'b0101, 4'b0000);
      rd_chk("af_flags", REG_AF, 16'h12A0);
      wr_reg(REG_F, 16'h005F, 4'b1000, 4'b1000);
      check("f_override", {24'd0, f_out}, 32'h000000D0);
      wr_reg(REG_BC, 16'hABCD, 4'd0, 4'd0);
      rd_chk("rd_b", REG_B, 16'h00AB);
      rd_chk("rd_c", REG_C, 16'h00CD);
      wr_reg(REG_NONE, 16'hFFFF, 4'd0, 4'd0);
      rd_chk("none_noop", REG_BC, 16'hABCD);
      rd_chk("rd_none", REG_NONE, 16'h0000);
      wr_reg(REG_PC, 16'h4321, 4'd0, 4'd0);
      check("pc_write", {16'd0, pc_out}, 32'h00004321);

      // Zero-wait push, then pop back with a two-cycle ack delay.
      delay = 0;
      exp_wr.push_back({16'hFFFD, 8'hBE});
      exp_wr.push_back({16'hFFFC, 8'hEF});
      exp_sp.push_back(16'hFFFC);
      run_cmd(1'b0, 16'hBEEF, 3, 1'b0, 1'b0, 16'h0);
      delay = 2;
      exp_sp.push_back(16'hFFFE);
      exp_rd.push_back(16'hBEEF);
      run_cmd(1'b1, 16'h0000, 7, 1'b0, 1'b0, 16'h0);

`ifdef SP_LIMIT_CHECK_EN
      // Boundary: landing exactly on the limit is legal, one below is not.
      wr_reg(REG_SP, 16'hC002, 4'd0, 4'd0);
      delay = 0;
      exp_wr.push_back({16'hC001, 8'h56});
      exp_wr.push_back({16'hC000, 8'h78});
      exp_sp.push_back(16'hC000);
      run_cmd(1'b0, 16'h5678, 3, 1'b0, 1'b0, 16'h0);
      wr_reg(REG_SP, 16'hC001, 4'd0, 4'd0);
      exp_sp.push_back(16'hC001);
      run_cmd(1'b0, 16'h1111, 1, 1'b1, 1'b0, 16'h0);
      wr_reg(REG_SP, 16'h0001, 4'd0, 4'd0);
      exp_sp.push_back(16'h0001);
      run_cmd(1'b0, 16'h1234, 1, 1'b1, 1'b1, 16'h7777);
`else
      // Wrapping push with SP writes attempted in the accept and transfer cycles.
      wr_reg(REG_SP, 16'h0001, 4'd0, 4'd0);
      delay = 0;
      exp_wr.push_back({16'h0000, 8'h12});
      exp_wr.push_back({16'hFFFF, 8'h34});
      exp_sp.push_back(16'hFFFF);
      run_cmd(1'b0, 16'h1234, 3, 1'b0, 1'b1, 16'h7777);
      delay = 1;
      exp_sp.push_back(16'h0001);
      exp_rd.push_back(16'h1234);
      run_cmd(1'b1, 16'h0000, 5, 1'b0, 1'b0, 16'h0);
`endif
      rd_chk("a_kept", REG_A, 16'h0012);

      // Reset in the middle of a stalled push.
      delay = 5;
      @(negedge clk);
      stk_valid = 1'b1; stk_op = 1'b0; stk_wdata = 16'hCAFE;
      @(posedge clk); #1;
      stk_valid = 1'b0;
      @(negedge clk);
      check("mid_req", {31'd0, mem_req}, 32'd1);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      check("rst_mid_req", {31'd0, mem_req}, 32'd0);
      check("rst_mid_sp", {16'd0, sp_out}, 32'h0000FFFE);
      check("rst_mid_ready", {31'd0, stk_ready}, 32'd1);
      check("rst_mid_rdata", {16'd0, stk_rdata}, 32'd0);
      seen_done = 0;
      repeat (4) begin
         @(negedge clk);
         if (stk_done) seen_done++;
      end
      check("rst_no_done", seen_done, 0);
      rd_chk("rst_mid_a", REG_A, 16'h0000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire
